// File: rtl/ahb_if_wb_pkg.sv
// Shared definitions for the CPU bus interface with posted-write buffer.
// Holds the drain/access FSM state encoding, bus direction and strobe
// polarity constants, and the slave-index map used to decode the SPM.
package ahb_if_wb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StAccess = 2'd2,
        StStall  = 2'd3
    } bus_state_e;

    // rw encoding
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low strobe / request levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Slave-index map decoded from the address index field
    localparam int unsigned SLAVE_IDX_ROM = 0;
    localparam int unsigned SLAVE_IDX_SPM = 1;
    localparam int unsigned SLAVE_IDX_UART = 2;
    localparam int unsigned SLAVE_IDX_GPIO = 3;

endpackage

// File: rtl/ahb_if_wb_if.sv
// Signal bundle between a CPU pipeline stage, its SPM and the bus arbiter.
// slave  : view taken by the ahb_if_wb interface unit.
// master : view taken by the environment (CPU stage, SPM, arbiter model).
// Groups: CPU side (stall/flush/busy/addr/as_/rw/wr_data/rd_data),
//         SPM side (spm_*), bus side (bus_*), status (bus_err/err_addr/wb_count).
interface ahb_if_wb_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WB_DEPTH = 4
) ();

    // CPU side
    logic                      stall;
    logic                      flush;
    logic                      busy;
    logic [ADDR_W-1:0]         addr;
    logic                      as_;
    logic                      rw;
    logic [DATA_W-1:0]         wr_data;
    logic [DATA_W-1:0]         rd_data;
    // SPM side
    logic [DATA_W-1:0]         spm_rd_data;
    logic [ADDR_W-1:0]         spm_addr;
    logic                      spm_as_;
    logic                      spm_rw;
    logic [DATA_W-1:0]         spm_wr_data;
    // Bus side
    logic [DATA_W-1:0]         bus_rd_data;
    logic                      bus_rdy_;
    logic                      bus_grnt_;
    logic                      bus_req_;
    logic [ADDR_W-1:0]         bus_addr;
    logic                      bus_as_;
    logic                      bus_rw;
    logic [DATA_W-1:0]         bus_wr_data;
    // Status
    logic                      bus_err;
    logic [ADDR_W-1:0]         err_addr;
    logic [$clog2(WB_DEPTH):0] wb_count;

    modport slave (
        input  stall, flush, addr, as_, rw, wr_data,
        input  spm_rd_data, bus_rd_data, bus_rdy_, bus_grnt_,
        output busy, rd_data,
        output spm_addr, spm_as_, spm_rw, spm_wr_data,
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        output bus_err, err_addr, wb_count
    );

    modport master (
        output stall, flush, addr, as_, rw, wr_data,
        output spm_rd_data, bus_rd_data, bus_rdy_, bus_grnt_,
        input  busy, rd_data,
        input  spm_addr, spm_as_, spm_rw, spm_wr_data,
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        input  bus_err, err_addr, wb_count
    );

endinterface

// File: rtl/ahb_wb_fifo.sv
// Synchronous FIFO holding posted bus writes as {addr, data} entries.
// Ports: clk/reset, push_i + wdata_i, pop_i, rdata_o (head entry, valid when
// !empty_o), full_o, empty_o, count_o (occupancy 0..DEPTH).
// Push while full and pop while empty are ignored. DEPTH must be a power of 2.
module ahb_wb_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ahb_if_wb.sv
// CPU bus interface with a posted-write buffer and bus-access timeout.
// Ports: clk, reset (async, active-high), bif (ahb_if_wb_if.slave) carrying
// the CPU stage, SPM and bus arbiter signals plus bus_err/err_addr/wb_count.
// SPM accesses complete combinationally. Bus writes are posted into a FIFO
// and drained in the background; bus reads wait until the FIFO is empty so
// that reads never overtake earlier writes. An ACCESS that sees no bus_rdy_
// for TIMEOUT cycles is aborted and reported on bus_err/err_addr.
module ahb_if_wb
    import ahb_if_wb_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned IDX_MSB   = 29,
    parameter int unsigned IDX_LSB   = 27,
    parameter int unsigned SPM_INDEX = SLAVE_IDX_SPM,
    parameter int unsigned WB_DEPTH  = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic            clk,
    input logic            reset,
    ahb_if_wb_if.slave     bif
);

    localparam int unsigned CNT_W  = $clog2(WB_DEPTH) + 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned IDX_W  = IDX_MSB - IDX_LSB + 1;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam logic [IDX_W-1:0] SPM_IDX = IDX_W'(SPM_INDEX);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    // FSM and registered bus outputs
    bus_state_e        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic              bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic              bus_err_q, bus_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    // CPU-side decode
    logic valid, is_spm, bus_wr_acc, bus_rd_acc;
    logic access_done, timeout_hit, rd_done;
    logic busy, spm_as_;
    logic [DATA_W-1:0] rd_data;

    // Write buffer
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   wb_count;

    assign valid      = (bif.as_ == ENABLE_) && !bif.flush;
    assign is_spm     = (bif.addr[IDX_MSB:IDX_LSB] == SPM_IDX);
    assign bus_wr_acc = valid && !is_spm && (bif.rw == WRITE);
    assign bus_rd_acc = valid && !is_spm && (bif.rw == READ);

    assign timeout_hit = (state_q == StAccess) && (bif.bus_rdy_ == DISABLE_) &&
                         (to_cnt_q == TO_LAST);
    assign access_done = (state_q == StAccess) &&
                         ((bif.bus_rdy_ == ENABLE_) || timeout_hit);
    assign rd_done     = access_done && (bus_rw_q == READ);

    ahb_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WB_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({bif.addr, bif.wr_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (wb_count)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: pending writes take priority over a new read
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty || bus_rd_acc) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bif.bus_grnt_ == ENABLE_) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (access_done) begin
                    state_d = (rd_done && bif.stall) ? StStall : StIdle;
                end
            end
            StStall: begin
                if (!bif.stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: bus register next values, FIFO control, CPU/SPM path
    always_comb begin
        bus_req_d     = bus_req_q;
        bus_as_d      = bus_as_q;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        err_addr_d    = err_addr_q;
        rd_buf_d      = rd_buf_q;
        to_cnt_d      = to_cnt_q;
        bus_err_d     = timeout_hit;
        fifo_pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    bus_addr_d    = fifo_head[ENTRY_W-1:DATA_W];
                    bus_wr_data_d = fifo_head[DATA_W-1:0];
                    bus_rw_d      = WRITE;
                    bus_req_d     = ENABLE_;
                end else if (bus_rd_acc) begin
                    bus_addr_d = bif.addr;
                    bus_rw_d   = READ;
                    bus_req_d  = ENABLE_;
                end
            end
            StReq: begin
                if (bif.bus_grnt_ == ENABLE_) begin
                    bus_as_d = ENABLE_;
                    to_cnt_d = '0;
                end
            end
            StAccess: begin
                if (access_done) begin
                    bus_req_d     = DISABLE_;
                    bus_as_d      = DISABLE_;
                    bus_addr_d    = '0;
                    bus_wr_data_d = '0;
                    bus_rw_d      = READ;
                    // A timed-out write is popped too, i.e. dropped
                    if (bus_rw_q == WRITE) begin
                        fifo_pop = 1'b1;
                    end else begin
                        rd_buf_d = timeout_hit ? '0 : bif.bus_rd_data;
                    end
                    if (timeout_hit) begin
                        err_addr_d = bus_addr_q;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // CPU/SPM combinational path
        busy    = 1'b0;
        rd_data = '0;
        spm_as_ = DISABLE_;
        if (rd_done) begin
            rd_data = timeout_hit ? '0 : bif.bus_rd_data;
        end else if (state_q == StStall) begin
            rd_data = rd_buf_q;
        end
        if (bus_wr_acc && fifo_full) begin
            busy = 1'b1;
        end
        if (bus_rd_acc && !rd_done && (state_q != StStall)) begin
            busy = 1'b1;
        end
        // SPM data wins over a discarded (flushed) bus read completing now
        if (valid && is_spm && !bif.stall) begin
            spm_as_ = ENABLE_;
            if (bif.rw == READ) begin
                rd_data = bif.spm_rd_data;
            end
        end
        // No push while full, even if the head is popped this cycle
        fifo_push = bus_wr_acc && !fifo_full && !bif.stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req_q     <= DISABLE_;
            bus_as_q      <= DISABLE_;
            bus_rw_q      <= READ;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            bus_err_q     <= 1'b0;
            err_addr_q    <= '0;
            rd_buf_q      <= '0;
            to_cnt_q      <= '0;
        end else begin
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_err_q     <= bus_err_d;
            err_addr_q    <= err_addr_d;
            rd_buf_q      <= rd_buf_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign bif.busy        = busy;
    assign bif.rd_data     = rd_data;
    assign bif.spm_addr    = bif.addr;
    assign bif.spm_as_     = spm_as_;
    assign bif.spm_rw      = bif.rw;
    assign bif.spm_wr_data = bif.wr_data;
    assign bif.bus_req_    = bus_req_q;
    assign bif.bus_as_     = bus_as_q;
    assign bif.bus_rw      = bus_rw_q;
    assign bif.bus_addr    = bus_addr_q;
    assign bif.bus_wr_data = bus_wr_data_q;
    assign bif.bus_err     = bus_err_q;
    assign bif.err_addr    = err_addr_q;
    assign bif.wb_count    = wb_count;

endmodule

// File: tb/tb_ahb_if_wb.sv
// Directed bench for ahb_if_wb: SPM path, posted writes and FIFO full,
// read-after-write ordering, timeout abort, stalled read, flush, async reset.
module tb_ahb_if_wb;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ahb_if_wb_if #(.DATA_W(32), .ADDR_W(32), .WB_DEPTH(4)) bus_if ();

    ahb_if_wb #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .IDX_MSB   (29),
        .IDX_LSB   (27),
        .SPM_INDEX (1),
        .WB_DEPTH  (4),
        .TIMEOUT   (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus_if.bus_req_ !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("req_wait", 64'(bus_if.bus_req_), 64'h0);
    endtask

    // Grant and complete one buffered write drain currently requesting
    task automatic serve_write(input logic [31:0] a, input logic [31:0] d);
        wait_req();
        check("drain_addr", 64'(bus_if.bus_addr), 64'(a));
        check("drain_wdata", 64'(bus_if.bus_wr_data), 64'(d));
        check("drain_rw", 64'(bus_if.bus_rw), 64'h0);
        bus_if.bus_grnt_ = 1'b0;
        tick();
        bus_if.bus_grnt_ = 1'b1;
        bus_if.bus_rdy_  = 1'b0;
        #1;
        check("drain_as", 64'(bus_if.bus_as_), 64'h0);
        tick();
        bus_if.bus_rdy_ = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus_if.stall       = 1'b0;
        bus_if.flush       = 1'b0;
        bus_if.addr        = '0;
        bus_if.as_         = 1'b1;
        bus_if.rw          = 1'b1;
        bus_if.wr_data     = '0;
        bus_if.spm_rd_data = '0;
        bus_if.bus_rd_data = '0;
        bus_if.bus_rdy_    = 1'b1;
        bus_if.bus_grnt_   = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst_req", 64'(bus_if.bus_req_), 64'h1);
        check("rst_as", 64'(bus_if.bus_as_), 64'h1);
        check("rst_rw", 64'(bus_if.bus_rw), 64'h1);
        check("rst_addr", 64'(bus_if.bus_addr), 64'h0);
        check("rst_wdata", 64'(bus_if.bus_wr_data), 64'h0);
        check("rst_err", 64'(bus_if.bus_err), 64'h0);
        check("rst_err_addr", 64'(bus_if.err_addr), 64'h0);
        check("rst_count", 64'(bus_if.wb_count), 64'h0);
        check("rst_busy", 64'(bus_if.busy), 64'h0);
        check("rst_spm_as", 64'(bus_if.spm_as_), 64'h1);
        reset = 1'b0;
        tick();

        // SPM read, same-cycle completion
        bus_if.as_ = 1'b0;
        bus_if.rw = 1'b1;
        bus_if.addr = 32'h0800_0010;
        bus_if.spm_rd_data = 32'hCAFE_F00D;
        #1;
        check("spm_as", 64'(bus_if.spm_as_), 64'h0);
        check("spm_rdata", 64'(bus_if.rd_data), 64'hCAFE_F00D);
        check("spm_busy", 64'(bus_if.busy), 64'h0);
        check("spm_addr", 64'(bus_if.spm_addr), 64'h0800_0010);
        bus_if.stall = 1'b1;
        #1;
        check("spm_stall_as", 64'(bus_if.spm_as_), 64'h1);
        bus_if.stall = 1'b0;
        tick();
        check("spm_no_req", 64'(bus_if.bus_req_), 64'h1);
        bus_if.as_ = 1'b1;
        tick();

        // Four posted writes, grant withheld, then a fifth hits a full FIFO
        bus_if.as_ = 1'b0;
        bus_if.rw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.addr = 32'(i * 4);
            bus_if.wr_data = 32'h1111_0000 + 32'(i * 4);
            #1;
            check("wr_busy", 64'(bus_if.busy), 64'h0);
            check("wr_count", 64'(bus_if.wb_count), 64'(i));
            tick();
        end
        bus_if.addr = 32'h10;
        bus_if.wr_data = 32'h1111_0010;
        #1;
        check("full_busy", 64'(bus_if.busy), 64'h1);
        check("full_count", 64'(bus_if.wb_count), 64'h4);
        check("full_req", 64'(bus_if.bus_req_), 64'h0);
        check("full_head_addr", 64'(bus_if.bus_addr), 64'h0);
        check("full_head_data", 64'(bus_if.bus_wr_data), 64'h1111_0000);
        bus_if.bus_grnt_ = 1'b0;
        tick();
        bus_if.bus_grnt_ = 1'b1;
        bus_if.bus_rdy_ = 1'b0;
        #1;
        check("pop_cycle_busy", 64'(bus_if.busy), 64'h1);
        check("pop_cycle_as", 64'(bus_if.bus_as_), 64'h0);
        tick();
        bus_if.bus_rdy_ = 1'b1;
        #1;
        check("after_pop_busy", 64'(bus_if.busy), 64'h0);
        check("after_pop_count", 64'(bus_if.wb_count), 64'h3);
        check("after_pop_req", 64'(bus_if.bus_req_), 64'h1);
        check("after_pop_addr", 64'(bus_if.bus_addr), 64'h0);
        tick();
        bus_if.as_ = 1'b1;
        #1;
        check("refill_count", 64'(bus_if.wb_count), 64'h4);
        serve_write(32'h4, 32'h1111_0004);
        serve_write(32'h8, 32'h1111_0008);
        serve_write(32'hC, 32'h1111_000C);
        serve_write(32'h10, 32'h1111_0010);
        #1;
        check("drained_count", 64'(bus_if.wb_count), 64'h0);

        // Write then read the same address: read waits for the drain
        bus_if.as_ = 1'b0;
        bus_if.rw = 1'b0;
        bus_if.addr = 32'h100;
        bus_if.wr_data = 32'hDEAD_BEEF;
        #1;
        check("raw_wr_busy", 64'(bus_if.busy), 64'h0);
        tick();
        bus_if.rw = 1'b1;
        bus_if.wr_data = '0;
        #1;
        check("raw_rd_busy0", 64'(bus_if.busy), 64'h1);
        check("raw_rd_noreq", 64'(bus_if.bus_req_), 64'h1);
        tick();
        check("raw_wreq", 64'(bus_if.bus_req_), 64'h0);
        check("raw_wreq_rw", 64'(bus_if.bus_rw), 64'h0);
        check("raw_wreq_data", 64'(bus_if.bus_wr_data), 64'hDEAD_BEEF);
        bus_if.bus_grnt_ = 1'b0;
        tick();
        bus_if.bus_grnt_ = 1'b1;
        bus_if.bus_rdy_ = 1'b0;
        #1;
        check("raw_wacc_busy", 64'(bus_if.busy), 64'h1);
        tick();
        bus_if.bus_rdy_ = 1'b1;
        #1;
        check("raw_gap_req", 64'(bus_if.bus_req_), 64'h1);
        check("raw_gap_busy", 64'(bus_if.busy), 64'h1);
        check("raw_gap_count", 64'(bus_if.wb_count), 64'h0);
        tick();
        check("raw_rreq", 64'(bus_if.bus_req_), 64'h0);
        check("raw_rreq_rw", 64'(bus_if.bus_rw), 64'h1);
        check("raw_rreq_addr", 64'(bus_if.bus_addr), 64'h100);
        bus_if.bus_grnt_ = 1'b0;
        tick();
        bus_if.bus_grnt_ = 1'b1;
        bus_if.bus_rdy_ = 1'b0;
        bus_if.bus_rd_data = 32'hA5A5_0100;
        #1;
        check("raw_rdata", 64'(bus_if.rd_data), 64'hA5A5_0100);
        check("raw_done_busy", 64'(bus_if.busy), 64'h0);
        tick();
        bus_if.bus_rdy_ = 1'b1;
        bus_if.as_ = 1'b1;
        #1;
        check("raw_idle_req", 64'(bus_if.bus_req_), 64'h1);
        check("raw_idle_rdata", 64'(bus_if.rd_data), 64'h0);

        // Read timeout after 8 ACCESS cycles
        bus_if.as_ = 1'b0;
        bus_if.rw = 1'b1;
        bus_if.addr = 32'h200;
        bus_if.bus_rd_data = 32'hFFFF_FFFF;
        tick();
        check("to_req", 64'(bus_if.bus_req_), 64'h0);
        bus_if.bus_grnt_ = 1'b0;
        tick();
        bus_if.bus_grnt_ = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("to_wait_busy", 64'(bus_if.busy), 64'h1);
            tick();
        end
        #1;
        check("to_abort_busy", 64'(bus_if.busy), 64'h0);
        check("to_abort_rdata", 64'(bus_if.rd_data), 64'h0);
        check("to_abort_err0", 64'(bus_if.bus_err), 64'h0);
        tick();
        bus_if.as_ = 1'b1;
        #1;
        check("to_err_pulse", 64'(bus_if.bus_err), 64'h1);
        check("to_err_addr", 64'(bus_if.err_addr), 64'h200);
        check("to_req_off", 64'(bus_if.bus_req_), 64'h1);
        check("to_as_off", 64'(bus_if.bus_as_), 64'h1);
        tick();
        check("to_err_clear", 64'(bus_if.bus_err), 64'h0);

        // Read completing under stall: data held from rd_buf
        bus_if.as_ = 1'b0;
        bus_if.rw = 1'b1;
        bus_if.addr = 32'h300;
        tick();
        bus_if.bus_grnt_ = 1'b0;
        tick();
        bus_if.bus_grnt_ = 1'b1;
        bus_if.bus_rdy_ = 1'b0;
        bus_if.stall = 1'b1;
        bus_if.bus_rd_data = 32'h1234_5678;
        #1;
        check("st_done_rdata", 64'(bus_if.rd_data), 64'h1234_5678);
        check("st_done_busy", 64'(bus_if.busy), 64'h0);
        tick();
        bus_if.bus_rdy_ = 1'b1;
        bus_if.bus_rd_data = '0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("st_hold_rdata", 64'(bus_if.rd_data), 64'h1234_5678);
            tick();
        end
        bus_if.stall = 1'b0;
        #1;
        check("st_release_rdata", 64'(bus_if.rd_data), 64'h1234_5678);
        check("st_release_busy", 64'(bus_if.busy), 64'h0);
        tick();
        bus_if.as_ = 1'b1;
        #1;
        check("st_idle_rdata", 64'(bus_if.rd_data), 64'h0);
        tick();
        check("st_no_reissue", 64'(bus_if.bus_req_), 64'h1);

        // Flushed read is suppressed
        bus_if.as_ = 1'b0;
        bus_if.rw = 1'b1;
        bus_if.addr = 32'h500;
        bus_if.flush = 1'b1;
        #1;
        check("flush_busy", 64'(bus_if.busy), 64'h0);
        tick();
        check("flush_no_req", 64'(bus_if.bus_req_), 64'h1);
        bus_if.flush = 1'b0;
        bus_if.as_ = 1'b1;

        // Async reset during a write drain with two entries buffered
        bus_if.as_ = 1'b0;
        bus_if.rw = 1'b0;
        bus_if.addr = 32'h400;
        bus_if.wr_data = 32'h1;
        tick();
        bus_if.addr = 32'h404;
        bus_if.wr_data = 32'h2;
        tick();
        bus_if.as_ = 1'b1;
        bus_if.bus_grnt_ = 1'b0;
        tick();
        bus_if.bus_grnt_ = 1'b1;
        check("rs_count2", 64'(bus_if.wb_count), 64'h2);
        check("rs_in_access", 64'(bus_if.bus_as_), 64'h0);
        #2;
        reset = 1'b1;
        #1;
        check("rs_async_as", 64'(bus_if.bus_as_), 64'h1);
        check("rs_async_req", 64'(bus_if.bus_req_), 64'h1);
        check("rs_async_count", 64'(bus_if.wb_count), 64'h0);
        check("rs_async_addr", 64'(bus_if.bus_addr), 64'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rs_quiet_req", 64'(bus_if.bus_req_), 64'h1);
            check("rs_quiet_count", 64'(bus_if.wb_count), 64'h0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_if_wb.md
Name: ahb_if_wb

Overview:
- Parametrised next-generation CPU bus interface with a posted-write buffer and a bus-access timeout.
- Sits between one CPU pipeline stage (IF or MEM) and the local SPM/bus arbiter.
- SPM accesses complete in the same cycle, as before.
- Bus writes are queued in a FIFO and drained in the background. Bus reads wait for the FIFO to drain, which preserves read-after-write ordering.

Parameters:
- DATA_W, 32, data path width.
- ADDR_W, 32, address width.
- IDX_MSB, 29, MSB of the slave-index field in addr.
- IDX_LSB, 27, LSB of the slave-index field in addr.
- SPM_INDEX, 1, slave index that selects the SPM.
- WB_DEPTH, 4, write-buffer entries; must be a power of 2, ≥2.
- TIMEOUT, 255, maximum ACCESS cycles without bus_rdy_ before abort; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- stall  in  1  pipeline stall
- flush  in  1  pipeline flush
- busy  out  1  interface cannot complete this cycle's access
- addr  in  ADDR_W  CPU address
- as_  in  1  CPU address strobe, active-low
- rw  in  1  READ=1, WRITE=0
- wr_data  in  DATA_W  CPU write data
- rd_data  out  DATA_W  read data to CPU
- spm_rd_data  in  DATA_W  SPM read data
- spm_addr  out  ADDR_W  SPM address; equals addr
- spm_as_  out  1  SPM strobe, active-low
- spm_rw  out  1  SPM read/write; equals rw
- spm_wr_data  out  DATA_W  SPM write data; equals wr_data
- bus_rd_data  in  DATA_W  bus read data
- bus_rdy_  in  1  bus ready, active-low
- bus_grnt_  in  1  bus grant, active-low
- bus_req_  out  1  bus request, active-low
- bus_addr  out  ADDR_W  bus address
- bus_as_  out  1  bus strobe, active-low
- bus_rw  out  1  bus read/write
- bus_wr_data  out  DATA_W  bus write data
- bus_err  out  1  one-cycle pulse on timeout
- err_addr  out  ADDR_W  address of the last timed-out access
- wb_count  out  $clog2(WB_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
  - On reset: bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0, bus_wr_data=0, bus_err=0, err_addr=0, wb_count=0.
  - FIFO pointers cleared, timeout counter=0, state=IDLE.
  - A reset mid-transaction drops all buffered writes.
- Combinational defaults: rd_data=0, spm_as_=1, busy=0.
- A CPU access is "valid" when as_=0 and flush=0.
- SPM access (valid, addr[IDX_MSB:IDX_LSB]==SPM_INDEX):
  - With stall=0: spm_as_=0 in the same cycle; for a read, rd_data=spm_rd_data.
  - Never blocked by the FIFO or by the drain engine.
- Bus write (valid, non-SPM, rw=WRITE):
  - wb_count<WB_DEPTH and stall=0: push {addr,wr_data}, busy=0, zero-wait.
  - FIFO full: busy=1, no push. No same-cycle push-on-pop when full.
- Bus read (valid, non-SPM, rw=READ): busy=1 until the read completes. The read is issued only when the FIFO is empty.
- Drain/access FSM states: IDLE, REQ, ACCESS, STALL.
  - IDLE, FIFO non-empty: load bus_addr/bus_wr_data from the FIFO head, bus_rw=WRITE, bus_req_=0, go to REQ.
  - IDLE, FIFO empty and valid non-SPM read: latch addr, bus_rw=READ, bus_req_=0, go to REQ.
  - REQ: on bus_grnt_=0, bus_as_=0, clear the timeout counter, go to ACCESS. bus_req_ stays 0.
  - ACCESS with bus_rdy_=0: deassert req/as, zero bus_addr and bus_wr_data, set bus_rw=READ.
    - Write: pop the FIFO, go to IDLE. One idle cycle separates back-to-back drains.
    - Read: rd_data=bus_rd_data and busy=0 this cycle; capture rd_buf. Go to STALL if stall=1, else IDLE.
  - ACCESS with bus_rdy_=1: increment the counter. When counter==TIMEOUT-1, abort:
    - Deassert req/as; bus_err=1 next cycle for one cycle; err_addr=bus_addr.
    - Write: entry popped (dropped).
    - Read: rd_buf=0, then follows the same completion path as a normal read (rd_data=0 and busy=0 in the abort cycle; STALL/IDLE on stall).
  - STALL: rd_data=rd_buf for a read. Go to IDLE when stall=0.
- Flush:
  - Never cancels buffered writes.
  - Suppresses a read that has not yet left IDLE.
  - Does not abort an issued read; its data is discarded by the pipeline.
- Simultaneous events:
  - A CPU push and a FIFO pop in the same cycle: wb_count unchanged.
  - An SPM access in parallel with a drain is allowed.
- Pointer wrap: modulo WB_DEPTH. wb_count saturates at WB_DEPTH by construction.

Decomposition:
- Shared bus header/package holds:
  - FSM state encodings (IDLE/REQ/ACCESS/STALL).
  - READ/WRITE, ENABLE_/DISABLE_ and slave-index constants.
- Sub-module: ahb_wb_fifo, a synchronous FIFO parametrised by width (ADDR_W+DATA_W) and WB_DEPTH, with push/pop/full/empty/count.
- The top level holds the FSM, the timeout counter and the combinational CPU/SPM path.

Test Plan:
- SPM read at 0x08000010 (index 1), stall=0 -> spm_as_=0 and rd_data=spm_rd_data the same cycle, busy=0, no bus_req_.
- Four bus writes to 0x00000000..0x0000000C back-to-back with grant/ready withheld -> all accepted busy=0, wb_count=4; fifth write -> busy=1 until the first drain completes.
- Write 0xDEADBEEF to 0x00000100, then read 0x00000100 -> read bus_req_ only after the write's bus_rdy_ cycle; rd_data returns slave data and bus order is write then read.
- Bus read with bus_rdy_ never asserted, TIMEOUT=8 -> abort after 8 ACCESS cycles, bus_err one-cycle pulse, err_addr=read addr, rd_data=0, busy drops.
- Bus read completing with stall=1 for 3 cycles, data 0x12345678 -> state STALL, rd_data=0x12345678 each stall cycle, back to IDLE when stall=0.
- Reset asserted during ACCESS with wb_count=2 -> outputs return to reset values asynchronously, wb_count=0, no further bus activity.
